// File: rtl/alu_mem_exec_unit.sv
// Execute/memory slice of the multi-cycle MIPS datapath: ALU control decode, 32-bit ALU with flags,
// and the shared synchronous instruction/data memory. Define ALU_XOR_EN to add the XOR operation.
module alu_mem_exec_unit #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        alu_op,
    input  logic [5:0]        funct,
    input  logic [DATA_W-1:0] alu_a,
    input  logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_ctrl,
    output logic [DATA_W-1:0] alu_result,
    output logic              alu_zero,
    output logic              alu_carry,
    output logic              alu_overflow,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int MSB   = DATA_W - 1;

    localparam logic [3:0] CTRL_AND = 4'b0000;
    localparam logic [3:0] CTRL_OR  = 4'b0001;
    localparam logic [3:0] CTRL_ADD = 4'b0010;
    localparam logic [3:0] CTRL_SUB = 4'b0110;
    localparam logic [3:0] CTRL_SLT = 4'b0111;
    localparam logic [3:0] CTRL_NOR = 4'b1100;
    localparam logic [3:0] CTRL_BAD = 4'b1111;
`ifdef ALU_XOR_EN
    localparam logic [3:0] CTRL_XOR = 4'b0011;
`endif

    logic [3:0]        ctrl;
    logic [DATA_W:0]   add_full;
    logic [DATA_W:0]   sub_full;
    logic [DATA_W-1:0] result;
    logic              carry;
    logic              overflow;

    always_comb begin
        ctrl = CTRL_ADD;
        case (alu_op)
            2'b00:   ctrl = CTRL_ADD;
            2'b01:   ctrl = CTRL_SUB;
            2'b10: begin
                case (funct)
                    6'b100000: ctrl = CTRL_ADD;
                    6'b100010: ctrl = CTRL_SUB;
                    6'b100100: ctrl = CTRL_AND;
                    6'b100101: ctrl = CTRL_OR;
                    6'b101010: ctrl = CTRL_SLT;
                    6'b100111: ctrl = CTRL_NOR;
`ifdef ALU_XOR_EN
                    6'b100110: ctrl = CTRL_XOR;
`endif
                    default:   ctrl = CTRL_BAD;
                endcase
            end
            default: ctrl = CTRL_ADD;
        endcase
    end

    // Subtraction is A + ~B + 1 so its carry out means "no borrow".
    assign add_full = {1'b0, alu_a} + {1'b0, alu_b};
    assign sub_full = {1'b0, alu_a} + {1'b0, ~alu_b} + {{DATA_W{1'b0}}, 1'b1};

    always_comb begin
        result   = '0;
        carry    = 1'b0;
        overflow = 1'b0;
        case (ctrl)
            CTRL_AND: result = alu_a & alu_b;
            CTRL_OR:  result = alu_a | alu_b;
            CTRL_NOR: result = ~(alu_a | alu_b);
            CTRL_ADD: begin
                result   = add_full[DATA_W-1:0];
                carry    = add_full[DATA_W];
                overflow = (alu_a[MSB] == alu_b[MSB]) && (add_full[MSB] != alu_a[MSB]);
            end
            CTRL_SUB: begin
                result   = sub_full[DATA_W-1:0];
                carry    = sub_full[DATA_W];
                overflow = (alu_a[MSB] != alu_b[MSB]) && (sub_full[MSB] != alu_a[MSB]);
            end
            // A direct signed compare stays correct when A-B would overflow.
            CTRL_SLT: result = {{(DATA_W-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
`ifdef ALU_XOR_EN
            CTRL_XOR: result = alu_a ^ alu_b;
`endif
            default:  result = '0;
        endcase
    end

    assign alu_ctrl     = ctrl;
    assign alu_result   = result;
    assign alu_zero     = (result == '0);
    assign alu_carry    = carry;
    assign alu_overflow = overflow;

    logic [DATA_W-1:0] mem_array_q [0:DEPTH-1];
    logic [DATA_W-1:0] rdata_d;
    logic [DATA_W-1:0] rdata_q;
    logic              mem_we_d;

    always_comb begin
        mem_we_d = mem_write && !rst;
        rdata_d  = rdata_q;
        if (rst) begin
            rdata_d = '0;
        end else if (mem_read) begin
            rdata_d = mem_array_q[mem_addr];
        end
    end

    // Array contents deliberately survive reset; only the read register clears.
    always_ff @(posedge clk) begin
        if (mem_we_d) begin
            mem_array_q[mem_addr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        rdata_q <= rdata_d;
    end

    assign mem_rdata = rdata_q;

endmodule

// File: tb/tb_alu_mem_exec_unit.sv
// Scoreboard bench for alu_mem_exec_unit: directed vectors push expectations, a monitor pops and compares.
// Honours ALU_XOR_EN the same way as the design.
module tb_alu_mem_exec_unit;

    typedef struct {
        int          id;
        logic [3:0]  ctrl;
        logic [31:0] res;
        logic        z;
        logic        c;
        logic        v;
    } alu_exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  alu_op;
    logic [5:0]  funct;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        alu_carry;
    logic        alu_overflow;
    logic        mem_read;
    logic        mem_write;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    alu_exp_t    alu_exp_q[$];
    logic [31:0] mem_exp_q[$];
    logic        alu_valid  = 1'b0;
    logic        mem_active = 1'b0;
    int          checks = 0;
    int          passes = 0;
    int          alu_id = 0;
    int          mem_id = 0;

    alu_mem_exec_unit #(.ADDR_W(9), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .alu_op(alu_op), .funct(funct), .alu_a(alu_a), .alu_b(alu_b),
        .alu_ctrl(alu_ctrl), .alu_result(alu_result), .alu_zero(alu_zero),
        .alu_carry(alu_carry), .alu_overflow(alu_overflow),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            $display("[TB] FAIL %s #%0d: got %h expected %h", name, id, act, exp);
        end else begin
            passes++;
        end
    endtask

    // One memory cycle: drive at the falling edge, queue the word mem_rdata must show after the next rising edge.
    task automatic memCycle(input logic r, input logic rd, input logic wr, input logic [8:0] addr,
                            input logic [31:0] wdata, input logic [31:0] exp);
        @(negedge clk);
        rst       = r;
        mem_read  = rd;
        mem_write = wr;
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_active = 1'b1;
        mem_exp_q.push_back(exp);
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [5:0] fn, input logic [31:0] a,
                                 input logic [31:0] b, input logic [3:0] ctrl, input logic [31:0] res,
                                 input logic z, input logic c, input logic v);
        alu_exp_t e;
        @(negedge clk);
        alu_op = op;
        funct  = fn;
        alu_a  = a;
        alu_b  = b;
        alu_valid = 1'b1;
        e.id = alu_id;
        e.ctrl = ctrl;
        e.res = res;
        e.z = z;
        e.c = c;
        e.v = v;
        alu_exp_q.push_back(e);
        alu_id++;
    endtask

    // Monitor: whatever the DUT presents after a rising edge is matched against the oldest expectation.
    initial begin
        logic     mem_fire;
        logic     alu_fire;
        alu_exp_t e;
        forever begin
            @(posedge clk);
            mem_fire = mem_active;
            alu_fire = alu_valid;
            #1;
            if (mem_fire) begin
                checks++;
                if (mem_exp_q.size() == 0) begin
                    $display("[TB] FAIL mem_sb #%0d: got rdata %h with no expectation queued", mem_id, mem_rdata);
                end else begin
                    passes++;
                    checkOutput("mem_rdata", mem_id, mem_rdata, mem_exp_q.pop_front());
                end
                mem_id++;
            end
            if (alu_fire) begin
                checks++;
                if (alu_exp_q.size() == 0) begin
                    $display("[TB] FAIL alu_sb: got result %h with no expectation queued", alu_result);
                end else begin
                    passes++;
                    e = alu_exp_q.pop_front();
                    checkOutput("alu_ctrl", e.id, {28'd0, alu_ctrl}, {28'd0, e.ctrl});
                    checkOutput("alu_result", e.id, alu_result, e.res);
                    checkOutput("alu_zero", e.id, {31'd0, alu_zero}, {31'd0, e.z});
                    checkOutput("alu_carry", e.id, {31'd0, alu_carry}, {31'd0, e.c});
                    checkOutput("alu_overflow", e.id, {31'd0, alu_overflow}, {31'd0, e.v});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time %0t exceeded limit", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; mem_addr = '0; mem_wdata = '0;
        alu_op = 2'b00; funct = '0; alu_a = '0; alu_b = '0;

        // Memory: reset, write, read latency, read-first collision, reset-suppressed write, hold.
        memCycle(1'b1, 1'b0, 1'b0, 9'h000, 32'h0,        32'h0);
        memCycle(1'b1, 1'b1, 1'b0, 9'h000, 32'h0,        32'h0);
        memCycle(1'b0, 1'b0, 1'b1, 9'h1FF, 32'hDEADBEEF, 32'h0);
        memCycle(1'b0, 1'b0, 1'b1, 9'h003, 32'h11112222, 32'h0);
        memCycle(1'b0, 1'b1, 1'b0, 9'h1FF, 32'h0,        32'hDEADBEEF);
        memCycle(1'b0, 1'b1, 1'b1, 9'h1FF, 32'h12345678, 32'hDEADBEEF);
        memCycle(1'b0, 1'b1, 1'b0, 9'h1FF, 32'h0,        32'h12345678);
        memCycle(1'b0, 1'b0, 1'b0, 9'h003, 32'h0,        32'h12345678);
        memCycle(1'b0, 1'b1, 1'b0, 9'h003, 32'h0,        32'h11112222);
        memCycle(1'b1, 1'b1, 1'b1, 9'h003, 32'hAAAA5555, 32'h0);
        memCycle(1'b0, 1'b1, 1'b0, 9'h003, 32'h0,        32'h11112222);
        memCycle(1'b0, 1'b1, 1'b0, 9'h1FF, 32'h0,        32'h12345678);
        memCycle(1'b0, 1'b0, 1'b1, 9'h000, 32'h0000CAFE, 32'h12345678);
        memCycle(1'b0, 1'b1, 1'b0, 9'h000, 32'h0,        32'h0000CAFE);
        @(negedge clk);
        mem_active = 1'b0;
        mem_read = 1'b0;
        mem_write = 1'b0;

        // ALU: op, funct, A, B -> ctrl, result, zero, carry, overflow.
        applyStimulus(2'b10, 6'b100000, 32'h7FFFFFFF, 32'h00000001, 4'b0010, 32'h80000000, 1'b0, 1'b0, 1'b1);
        applyStimulus(2'b01, 6'b000000, 32'h00000005, 32'h00000005, 4'b0110, 32'h00000000, 1'b1, 1'b1, 1'b0);
        applyStimulus(2'b01, 6'b111111, 32'h00000003, 32'h00000005, 4'b0110, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
        applyStimulus(2'b10, 6'b101010, 32'hFFFFFFFF, 32'h00000001, 4'b0111, 32'h00000001, 1'b0, 1'b0, 1'b0);
        applyStimulus(2'b10, 6'b101010, 32'h80000000, 32'h7FFFFFFF, 4'b0111, 32'h00000001, 1'b0, 1'b0, 1'b0);
        applyStimulus(2'b10, 6'b101010, 32'h7FFFFFFF, 32'h80000000, 4'b0111, 32'h00000000, 1'b1, 1'b0, 1'b0);
        applyStimulus(2'b10, 6'b100100, 32'hF0F0F0F0, 32'h0FF00FF0, 4'b0000, 32'h00F000F0, 1'b0, 1'b0, 1'b0);
        applyStimulus(2'b10, 6'b100101, 32'hF0F0F0F0, 32'h0FF00FF0, 4'b0001, 32'hFFF0FFF0, 1'b0, 1'b0, 1'b0);
        applyStimulus(2'b10, 6'b100111, 32'hF0F0F0F0, 32'h0FF00FF0, 4'b1100, 32'h000F000F, 1'b0, 1'b0, 1'b0);
        applyStimulus(2'b10, 6'b111111, 32'hF0F0F0F0, 32'h0FF00FF0, 4'b1111, 32'h00000000, 1'b1, 1'b0, 1'b0);
        applyStimulus(2'b00, 6'b100100, 32'hFFFFFFFF, 32'h00000001, 4'b0010, 32'h00000000, 1'b1, 1'b1, 1'b0);
        applyStimulus(2'b11, 6'b000000, 32'h00000002, 32'h00000003, 4'b0010, 32'h00000005, 1'b0, 1'b0, 1'b0);
        applyStimulus(2'b01, 6'b000000, 32'h80000000, 32'h00000001, 4'b0110, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b1);
        applyStimulus(2'b10, 6'b100010, 32'h00000000, 32'h00000001, 4'b0110, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
        applyStimulus(2'b10, 6'b100000, 32'h80000000, 32'h80000000, 4'b0010, 32'h00000000, 1'b1, 1'b1, 1'b1);
`ifdef ALU_XOR_EN
        applyStimulus(2'b10, 6'b100110, 32'hF0F0F0F0, 32'h0FF00FF0, 4'b0011, 32'hFF00FF00, 1'b0, 1'b0, 1'b0);
`else
        applyStimulus(2'b10, 6'b100110, 32'hF0F0F0F0, 32'h0FF00FF0, 4'b1111, 32'h00000000, 1'b1, 1'b0, 1'b0);
`endif
        @(negedge clk);
        alu_valid = 1'b0;

        repeat (3) @(negedge clk);
        checks++;
        if (alu_exp_q.size() != 0 || mem_exp_q.size() != 0) begin
            $display("[TB] FAIL drain: got %0d alu / %0d mem expectations left, expected 0 / 0",
                     alu_exp_q.size(), mem_exp_q.size());
        end else begin
            passes++;
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
